uart_tx_rx_scheduler: RTL

- Controller between the CPU memory-mapped bus and UART_Full_Duplex.
- Buffers CPU-written TX bytes in a FIFO and sequences the UART transmitter one byte at a time. It issues one-cycle tx_send/tx_send_en pulses and waits for each frame to finish.
- Captures received bytes into a holding register, clears the UART RX flag, and reports ready, overrun and parity status back to the CPU.

---
 rtl/UART_pkg.sv | 17 +
 rtl/uart_sched_fifo.sv | 66 ++++++
 rtl/uart_tx_rx_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/UART_pkg.sv
// Shared types and defaults for the UART TX/RX scheduler.
package UART_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_GAP_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } sched_state_t;

endpackage

// File: rtl/uart_sched_fifo.sv
// TX byte FIFO for the UART scheduler: registered full/empty, combinational head,
// and a drop strobe when a push is refused because the FIFO is full.
module uart_sched_fifo
    import UART_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] din,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] head,
    output logic                   full,
    output logic                   empty,
    output logic                   drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic                   push_ok;
    logic                   pop_ok;

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_rx_scheduler.sv
// CPU-side scheduler for a full-duplex UART: queues TX bytes and holds RX bytes.
// Define UART_SCHED_PARITY_DROP_EN to discard parity-errored RX bytes (rx_perr then sticky).
module uart_tx_rx_scheduler
    import UART_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   rd_en,
    input  logic                   clr_flags,
    input  logic                   tx_idle,
    input  logic                   rx_done,
    input  logic [UART_DATA_W-1:0] Rx_Data,
    input  logic                   parity_error,
    output logic                   tx_send,
    output logic                   tx_send_en,
    output logic [UART_DATA_W-1:0] Tx_Data,
    output logic                   rx_data_clf,
    output logic [UART_DATA_W-1:0] rx_byte,
    output logic                   rx_ready,
    output logic                   rx_perr,
    output logic                   rx_overrun,
    output logic                   tx_overflow,
    output logic                   tx_full,
    output logic                   tx_empty,
    output logic                   tx_busy
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t           state;
    logic [GW-1:0]          gap_cnt;
    logic [UART_DATA_W-1:0] fifo_head;
    logic                   fifo_pop;
    logic                   fifo_drop;
    logic                   rx_take;

    uart_sched_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (wr_data),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (tx_full),
        .empty (tx_empty),
        .drop  (fifo_drop)
    );

    assign fifo_pop   = (state == LOAD);
    assign tx_send_en = tx_send;
    assign tx_busy    = (state != IDLE) || !tx_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            tx_send <= 1'b0;
            Tx_Data <= '0;
        end else begin
            tx_send <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_empty && tx_idle) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    Tx_Data <= fifo_head;
                    tx_send <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!tx_idle) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_idle) begin
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_SCHED_PARITY_DROP_EN
    assign rx_take = rx_done && !parity_error;
`else
    assign rx_take = rx_done;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_clf <= 1'b0;
            rx_byte     <= '0;
            rx_ready    <= 1'b0;
            rx_perr     <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            rx_data_clf <= rx_done;
            if (rx_take) begin
                rx_byte  <= Rx_Data;
                rx_ready <= 1'b1;
            end else if (rd_en) begin
                rx_ready <= 1'b0;
            end
            // A read in the same cycle means the old byte was consumed, not lost.
            if (rx_take && rx_ready && !rd_en) begin
                rx_overrun <= 1'b1;
            end else if (clr_flags) begin
                rx_overrun <= 1'b0;
            end
            if (fifo_drop) begin
                tx_overflow <= 1'b1;
            end else if (clr_flags) begin
                tx_overflow <= 1'b0;
            end
`ifdef UART_SCHED_PARITY_DROP_EN
            if (rx_done && parity_error) begin
                rx_perr <= 1'b1;
            end else if (clr_flags) begin
                rx_perr <= 1'b0;
            end
`else
            if (rx_take) begin
                rx_perr <= parity_error;
            end
`endif
        end
    end

endmodule
